// File: rtl/spi_baud_generator.sv
// -----------------------------------------------------------------------------
// spi_baud_generator
//
// Generates the SPI serial clock (sclk) from PCLK, plus two one-PCLK strobes
// that tell the shifter when to sample MISO and when to shift MOSI.
//
// Ports
//   PCLK               in   1  system clock, all state changes on rising edge
//   PRESETn            in   1  asynchronous active-low reset
//   spi_mode           in   2  00 run, 01 wait, 10/11 stop
//   spiswai            in   1  stop sclk generation while in wait mode
//   sppr               in   3  baud prescaler select
//   spr                in   3  baud rate select
//   cpol               in   1  sclk idle level
//   cpha               in   1  sclk phase
//   ss                 in   1  active-low slave select (low = transfer)
//   sclk               out  1  generated serial clock (registered)
//   miso_receive_sclk  out  1  one-PCLK sample strobe (registered)
//   mosi_send_sclk     out  1  one-PCLK shift strobe (registered)
//   baud_rate_divisor  out 12  (sppr+1) * 2^(spr+1), combinational
//
// Behaviour
//   The divisor is split into two half periods. While active, an 11-bit
//   counter runs from 0 to half_period-1; on reaching (or passing) that
//   limit it restarts and sclk toggles. A toggle away from cpol is a leading
//   edge, a toggle back to cpol is a trailing edge; cpha chooses which of the
//   two edges fires the sample strobe and which fires the shift strobe.
//   While inactive the counter is cleared, sclk parks at cpol and no strobe
//   is produced.
// -----------------------------------------------------------------------------
module spi_baud_generator (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [1:0]  spi_mode,
  input  logic        spiswai,
  input  logic [2:0]  sppr,
  input  logic [2:0]  spr,
  input  logic        cpol,
  input  logic        cpha,
  input  logic        ss,
  output logic        sclk,
  output logic        miso_receive_sclk,
  output logic        mosi_send_sclk,
  output logic [11:0] baud_rate_divisor
);

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_WAIT = 2'b01;

  logic [10:0] cnt_q, cnt_d;
  logic        sclk_q, sclk_d;
  logic        miso_q, miso_d;
  logic        mosi_q, mosi_d;

  logic [11:0] divisor;
  logic [10:0] half_period;
  logic [10:0] half_limit;
  logic        active;
  logic        toggle;
  logic        leading;

  // Shift amount is widened so spr=7 gives 2^8 rather than wrapping to 2^0.
  // Largest result is 8 * 256 = 2048, which still fits in 12 bits.
  assign divisor = (12'({9'd0, sppr}) + 12'd1) << ({1'b0, spr} + 4'd1);

  // Divisor is always even, so dropping bit 0 is an exact halving (1..1024).
  assign half_period = divisor[11:1];
  assign half_limit  = half_period - 11'd1;

  assign active = ~ss & ((spi_mode == MODE_RUN) |
                         ((spi_mode == MODE_WAIT) & ~spiswai));

  // ">=" rather than "==" so a divisor that shrinks below the current count
  // toggles on the next edge instead of running the counter all the way round.
  assign toggle = cnt_q >= half_limit;

  // Leading edge moves sclk away from the idle level.
  assign leading = (sclk_q == cpol);

  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    miso_d = 1'b0;
    mosi_d = 1'b0;
    if (!active) begin
      cnt_d  = 11'd0;
      sclk_d = cpol;
    end else if (toggle) begin
      cnt_d  = 11'd0;
      sclk_d = ~sclk_q;
      // cpha=0: sample on leading, shift on trailing; cpha=1 swaps them.
      if (leading ^ cpha) begin
        miso_d = 1'b1;
      end else begin
        mosi_d = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 11'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q  <= 11'd0;
      sclk_q <= 1'b0;
      miso_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      miso_q <= miso_d;
      mosi_q <= mosi_d;
    end
  end

  assign sclk              = sclk_q;
  assign miso_receive_sclk = miso_q;
  assign mosi_send_sclk    = mosi_q;
  assign baud_rate_divisor = divisor;

endmodule

// File: doc/spi_baud_generator.md
SPI_BAUD_GENERATOR -- requirements
Module: spi_baud_generator

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: PCLK is the only clock and PRESETn is the asynchronous active-low reset.
REQ-002 The module SHALL have these ports:
- PCLK  in  1  system clock; all state changes on its rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- spi_mode  in  2  00 run, 01 wait, 10 stop; 11 is treated as stop.
- spiswai  in  1  stop SCLK generation while in wait mode.
- sppr  in  3  baud prescaler select.
- spr  in  3  baud rate select.
- cpol  in  1  SCLK idle level.
- cpha  in  1  SCLK phase.
- ss  in  1  active-low slave select; low means a transfer is in progress.
- sclk  out  1  generated serial clock, registered.
- miso_receive_sclk  out  1  one-PCLK sample strobe, registered.
- mosi_send_sclk  out  1  one-PCLK shift strobe, registered.
- baud_rate_divisor  out  12  current divisor, combinational.

Function
REQ-003 baud_rate_divisor SHALL equal (sppr+1) * 2^(spr+1), computed at 12-bit width.
- Range is 2 (sppr=0, spr=0) to 2048 (sppr=7, spr=7).
- No overflow is possible at 12 bits.
REQ-004 half_period SHALL equal baud_rate_divisor/2, with range 1..1024.
REQ-005 The internal counter SHALL be 11 bits wide.
REQ-006 active SHALL be true when ss is 0 AND either:
- spi_mode is 00, or
- spi_mode is 01 with spiswai at 0.
REQ-007 While active is false, the following SHALL hold from the next PCLK edge:
- the counter is 0;
- sclk equals cpol;
- both strobes are 0.
REQ-008 While active is true, on each PCLK edge the counter SHALL behave as follows:
- if counter >= half_period-1, the counter goes to 0 and sclk toggles;
- otherwise the counter increments and sclk holds.
REQ-009 The ">=" comparison SHALL be used so that shrinking the divisor mid-count causes a toggle on the next edge rather than a counter wrap.
REQ-010 An SCLK edge is leading if it moves sclk away from cpol, and trailing otherwise.
REQ-011 On the same PCLK edge that toggles sclk, the strobes SHALL be set for exactly one cycle according to cpha:
- cpha=0: leading edge sets miso_receive_sclk=1; trailing edge sets mosi_send_sclk=1.
- cpha=1: leading edge sets mosi_send_sclk=1; trailing edge sets miso_receive_sclk=1.
REQ-012 The two strobes SHALL never be 1 in the same cycle.
REQ-013 Each strobe SHALL be 0 on every PCLK edge that does not toggle sclk.
REQ-014 The first SCLK edge after active rises SHALL occur half_period PCLK edges later, counting the first active edge as edge 1, and SHALL be a leading edge.
REQ-015 A change of cpol while active is false SHALL be reflected on sclk one PCLK edge later.
REQ-016 A change of cpol while active is true is a software error; the block SHALL continue toggling from its current sclk level and SHALL NOT glitch.
REQ-017 When active falls mid-period, the REQ-007 state SHALL take effect on the next edge, and no strobe SHALL be generated on that edge.
REQ-018 A change of sppr/spr SHALL take effect on the next compare, with no restart of the counter.

Reset
REQ-019 While PRESETn=0, asynchronously and regardless of PCLK, the module SHALL hold:
- counter=0;
- sclk=0;
- miso_receive_sclk=0;
- mosi_send_sclk=0.
REQ-020 After PRESETn releases, sclk SHALL follow REQ-007 (sclk=cpol) on the first PCLK edge.
REQ-021 A reset asserted mid-transfer SHALL abort the transfer immediately, with no pending strobe emitted afterwards.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Minimum divisor: sppr=0, spr=0, cpol=0, cpha=0, spi_mode=00, ss=0 -> baud_rate_divisor=2; sclk toggles every PCLK (0,1,0,1...); miso_receive_sclk on the rising edges, mosi_send_sclk on the falling edges.
- Mid divisor: sppr=2, spr=1 -> divisor=12; sclk low 6 PCLK, then high 6 PCLK; first rise on the 6th active edge; exactly one strobe per toggle.
- Inverted polarity and phase: cpol=1, cpha=1, divisor=4 -> idle sclk=1; first fall comes with mosi_send_sclk; the following rise comes with miso_receive_sclk.
- ss deasserted at counter=3 with divisor=16 -> next edge: sclk=cpol, counter=0, no strobe; reasserting ss gives the first edge 8 PCLK later.
- Wait/stop behaviour: spi_mode=01, spiswai=1 -> sclk frozen at cpol; spiswai=0 -> toggling resumes; spi_mode=10 -> frozen.
- Divisor shrink: at counter=5 with divisor=32, change to sppr=0, spr=0 -> toggle and strobe on the next edge, then toggle every edge.
- Reset: PRESETn pulsed low between PCLK edges while sclk=1 -> sclk and both strobes go 0 immediately without waiting for PCLK.
